// File: rtl/syspll_seq.sv
// Reset/lock sequencer for the OCXO system PLL: drives the PLL reset, qualifies lock and
// OCXO activity through synchronizers, retries failed attempts and reports status/counters.
module syspll_seq #(
  parameter int RST_CYCLES    = 64,
  parameter int LOCK_TIMEOUT  = 1000000,
  parameter int STABLE_CYCLES = 1024,
  parameter int ACT_WINDOW    = 256,
  parameter int MAX_RETRY     = 8,
  parameter int SYNC_STAGES   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        pll_locked,
  input  logic        ocxo_tick,
  output logic        pll_rst_n,
  output logic        pll_ok,
  output logic        fault,
  output logic [7:0]  retry_cnt,
  output logic [15:0] loss_cnt,
  output logic [2:0]  state
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int TMAX = max2(max2(RST_CYCLES, LOCK_TIMEOUT), max2(STABLE_CYCLES, ACT_WINDOW));
  localparam int TW   = $clog2(TMAX) + 1;
  localparam logic [TW-1:0] RST_LAST    = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STABLE_LAST = TW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] ACT_LAST    = TW'(ACT_WINDOW - 1);
  localparam logic [TW-1:0] T_ZERO      = {TW{1'b0}};
  localparam logic [TW-1:0] T_ONE       = TW'(32'd1);
  localparam logic [7:0]    RETRY_LIMIT = 8'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RST_HOLD  = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_STABILIZE = 3'd3,
    S_LOCKED    = 3'd4,
    S_FAULT     = 3'd5
  } state_e;

  state_e                 state_q, state_d, fail_state;
  logic [TW-1:0]          timer_q, timer_d, timer_inc;
  logic [7:0]             retry_q, retry_d, retry_sat;
  logic [15:0]            loss_q, loss_d, loss_sat;
  logic [SYNC_STAGES-1:0] lock_sync_q, lock_sync_d;
  logic [SYNC_STAGES-1:0] tick_sync_q, tick_sync_d;
  logic                   tick_prev_q, tick_prev_d;
  logic                   pll_rst_n_q, pll_rst_n_d;
  logic                   pll_ok_q, pll_ok_d;
  logic                   fault_q, fault_d;
  logic                   lock_s, tick_s, tick_edge;

  assign lock_s    = lock_sync_q[SYNC_STAGES-1];
  assign tick_s    = tick_sync_q[SYNC_STAGES-1];
  assign tick_edge = tick_s ^ tick_prev_q;

  // Synchronizer shift and tick history
  always_comb begin
    lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], pll_locked};
    tick_sync_d = {tick_sync_q[SYNC_STAGES-2:0], ocxo_tick};
    tick_prev_d = tick_s;
  end

  // Sequencer next-state, timer, counters and registered output values
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    retry_d   = retry_q;
    loss_d    = loss_q;
    timer_inc = (timer_q == {TW{1'b1}}) ? timer_q : timer_q + T_ONE;
    retry_sat = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
    loss_sat  = (loss_q == 16'hFFFF) ? loss_q : loss_q + 16'd1;
    fail_state = (retry_sat >= RETRY_LIMIT) ? S_FAULT : S_RST_HOLD;

    if (!enable) begin
      state_d = S_IDLE;
      timer_d = T_ZERO;
      retry_d = 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_RST_HOLD;
          timer_d = T_ZERO;
        end
        S_RST_HOLD: begin
          if (timer_q == RST_LAST) begin
            state_d = S_WAIT_LOCK;
            timer_d = T_ZERO;
          end else begin
            timer_d = timer_inc;
          end
        end
        S_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = S_STABILIZE;
            timer_d = T_ZERO;
          end else if (timer_q == LOCK_LAST) begin
            state_d = fail_state;
            retry_d = retry_sat;
            timer_d = T_ZERO;
          end else begin
            timer_d = timer_inc;
          end
        end
        S_STABILIZE: begin
          if (!lock_s) begin
            state_d = fail_state;
            retry_d = retry_sat;
            timer_d = T_ZERO;
          end else if (timer_q == STABLE_LAST) begin
            state_d = S_LOCKED;
            retry_d = 8'd0;
            timer_d = T_ZERO;
          end else begin
            timer_d = timer_inc;
          end
        end
        // In LOCKED the timer measures cycles since the last OCXO tick edge
        S_LOCKED: begin
          if (!lock_s || (!tick_edge && (timer_q == ACT_LAST))) begin
            state_d = fail_state;
            retry_d = retry_sat;
            loss_d  = loss_sat;
            timer_d = T_ZERO;
          end else if (tick_edge) begin
            timer_d = T_ZERO;
          end else begin
            timer_d = timer_inc;
          end
        end
        S_FAULT: begin
          state_d = S_FAULT;
        end
        default: begin
          state_d = S_IDLE;
          timer_d = T_ZERO;
        end
      endcase
    end

    pll_rst_n_d = (state_d == S_WAIT_LOCK) || (state_d == S_STABILIZE) || (state_d == S_LOCKED);
    pll_ok_d    = (state_d == S_LOCKED);
    fault_d     = (state_d == S_FAULT);
  end

  // State, timer, counter, synchronizer and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      timer_q     <= T_ZERO;
      retry_q     <= 8'd0;
      loss_q      <= 16'd0;
      lock_sync_q <= {SYNC_STAGES{1'b0}};
      tick_sync_q <= {SYNC_STAGES{1'b0}};
      tick_prev_q <= 1'b0;
      pll_rst_n_q <= 1'b0;
      pll_ok_q    <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      lock_sync_q <= lock_sync_d;
      tick_sync_q <= tick_sync_d;
      tick_prev_q <= tick_prev_d;
      pll_rst_n_q <= pll_rst_n_d;
      pll_ok_q    <= pll_ok_d;
      fault_q     <= fault_d;
    end
  end

  assign pll_rst_n = pll_rst_n_q;
  assign pll_ok    = pll_ok_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_q;
  assign loss_cnt  = loss_q;
  assign state     = state_q;

endmodule

// File: tb/tb_syspll_seq.sv
// Scoreboard bench for syspll_seq: a phase-level reference model predicts every cycle's
// outputs, a separate monitor compares them against the DUT.
module tb_syspll_seq;

  localparam int RC = 4;
  localparam int LT = 20;
  localparam int SC = 8;
  localparam int AW = 16;
  localparam int MR = 3;
  localparam int SS = 2;

  localparam int P_IDLE = 0;
  localparam int P_RST  = 1;
  localparam int P_WAIT = 2;
  localparam int P_STAB = 3;
  localparam int P_LOCK = 4;
  localparam int P_FLT  = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        pll_locked = 1'b0;
  logic        ocxo_tick = 1'b0;
  logic        pll_rst_n, pll_ok, fault;
  logic [7:0]  retry_cnt;
  logic [15:0] loss_cnt;
  logic [2:0]  state;

  syspll_seq #(
    .RST_CYCLES(RC), .LOCK_TIMEOUT(LT), .STABLE_CYCLES(SC),
    .ACT_WINDOW(AW), .MAX_RETRY(MR), .SYNC_STAGES(SS)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .pll_locked(pll_locked), .ocxo_tick(ocxo_tick),
    .pll_rst_n(pll_rst_n), .pll_ok(pll_ok), .fault(fault),
    .retry_cnt(retry_cnt), .loss_cnt(loss_cnt), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int st;
    int rn;
    int ok;
    int flt;
    int rc;
    int lc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_push = 0;
  int   n_pop = 0;

  // reference model: phase, cycles spent in it, quiet cycles since last tick edge
  int m_phase = P_IDLE;
  int m_spent = 0;
  int m_quiet = 0;
  int m_retry = 0;
  int m_loss = 0;
  int lock_h[SS];
  int tick_h[SS+1];

  int tick_per = 0;
  int tick_ctr = 0;

  function automatic void chk(input int c, input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL cycle %0d %s: got %0d expected %0d", c, nm, got, want);
    end
  endfunction

  task automatic model_edge();
    int ls;
    int te;
    bit failed;
    if (rst) begin
      m_phase = P_IDLE; m_spent = 0; m_quiet = 0; m_retry = 0; m_loss = 0;
      for (int i = 0; i < SS; i++) lock_h[i] = 0;
      for (int i = 0; i <= SS; i++) tick_h[i] = 0;
    end else begin
      ls = lock_h[SS-1];
      te = tick_h[SS-1] ^ tick_h[SS];
      for (int i = SS; i > 0; i--) tick_h[i] = tick_h[i-1];
      tick_h[0] = int'(ocxo_tick);
      for (int i = SS-1; i > 0; i--) lock_h[i] = lock_h[i-1];
      lock_h[0] = int'(pll_locked);
      failed = 1'b0;
      if (!enable) begin
        m_phase = P_IDLE;
        m_retry = 0;
      end else begin
        case (m_phase)
          P_IDLE: begin m_phase = P_RST; m_spent = 0; end
          P_RST: begin
            m_spent++;
            if (m_spent == RC) begin m_phase = P_WAIT; m_spent = 0; end
          end
          P_WAIT: begin
            if (ls != 0) begin m_phase = P_STAB; m_spent = 0; end
            else begin m_spent++; if (m_spent == LT) failed = 1'b1; end
          end
          P_STAB: begin
            if (ls == 0) failed = 1'b1;
            else begin
              m_spent++;
              if (m_spent == SC) begin m_phase = P_LOCK; m_retry = 0; m_quiet = 0; end
            end
          end
          P_LOCK: begin
            m_quiet = (te != 0) ? 0 : m_quiet + 1;
            if (ls == 0 || m_quiet == AW) begin
              failed = 1'b1;
              if (m_loss < 65535) m_loss++;
            end
          end
          default: ;
        endcase
        if (failed) begin
          if (m_retry < 255) m_retry++;
          m_phase = (m_retry >= MR) ? P_FLT : P_RST;
          m_spent = 0;
        end
      end
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    model_edge();
    e.cyc = cyc;
    e.st  = m_phase;
    e.rn  = (m_phase == P_WAIT || m_phase == P_STAB || m_phase == P_LOCK) ? 1 : 0;
    e.ok  = (m_phase == P_LOCK) ? 1 : 0;
    e.flt = (m_phase == P_FLT) ? 1 : 0;
    e.rc  = m_retry;
    e.lc  = m_loss;
    exp_q.push_back(e);
    n_push++;
    cyc++;
    #1;
    if (tick_per != 0) begin
      tick_ctr++;
      if (tick_ctr >= tick_per) begin
        tick_ctr = 0;
        ocxo_tick = ~ocxo_tick;
      end
    end
  endtask

  task automatic wait_phase(input int p, input int budget, input string nm);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      if (m_phase == p) hit = 1'b1;
      else step();
    end
    if (m_phase == p) hit = 1'b1;
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL wait_%s: phase %0d after %0d cycles, expected %0d", nm, m_phase, budget, p);
    end
  endtask

  // monitor: compare every presented output set against the scoreboard
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_pop++;
      chk(mon_e.cyc, "state",     int'(state),     mon_e.st);
      chk(mon_e.cyc, "pll_rst_n", int'(pll_rst_n), mon_e.rn);
      chk(mon_e.cyc, "pll_ok",    int'(pll_ok),    mon_e.ok);
      chk(mon_e.cyc, "fault",     int'(fault),     mon_e.flt);
      chk(mon_e.cyc, "retry_cnt", int'(retry_cnt), mon_e.rc);
      chk(mon_e.cyc, "loss_cnt",  int'(loss_cnt),  mon_e.lc);
    end
  end

  int en_cd;
  int lock_cd;

  initial begin
    for (int i = 0; i < SS; i++) lock_h[i] = 0;
    for (int i = 0; i <= SS; i++) tick_h[i] = 0;
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();

    // bring-up: lock appears around cycle 10, OCXO toggles every 8
    enable = 1'b1;
    tick_per = 8;
    repeat (10) step();
    pll_locked = 1'b1;
    wait_phase(P_LOCK, 100, "first_lock");
    repeat (20) step();

    // single-cycle lock drop while locked
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    wait_phase(P_RST, 20, "loss_retry");
    wait_phase(P_LOCK, 100, "relock");
    repeat (10) step();

    // OCXO activity stops
    tick_per = 0;
    wait_phase(P_RST, 60, "act_loss");
    tick_per = 5;
    wait_phase(P_LOCK, 100, "act_relock");
    repeat (10) step();

    // glitch during stabilization
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    wait_phase(P_STAB, 100, "stab_entry");
    repeat (3) step();
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    wait_phase(P_RST, 10, "stab_glitch");
    wait_phase(P_LOCK, 100, "glitch_relock");

    // retries exhaust into FAULT, then enable toggle restarts
    pll_locked = 1'b0;
    wait_phase(P_FLT, 200, "fault");
    repeat (5) step();
    enable = 1'b0;
    repeat (3) step();
    enable = 1'b1;
    repeat (10) step();
    pll_locked = 1'b1;
    wait_phase(P_LOCK, 100, "fault_recover");

    // enable dropped mid WAIT_LOCK
    pll_locked = 1'b0;
    wait_phase(P_WAIT, 40, "wait_entry");
    repeat (5) step();
    enable = 1'b0;
    repeat (2) step();
    enable = 1'b1;
    pll_locked = 1'b1;
    wait_phase(P_LOCK, 100, "en_relock");

    // reset while locked
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (2) step();
    wait_phase(P_LOCK, 100, "rst_relock");

    // randomized traffic
    en_cd = 0;
    lock_cd = 0;
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 599) == 0);
      if (en_cd > 0) begin
        en_cd--;
        enable = 1'b0;
      end else if ($urandom_range(0, 249) == 0) begin
        enable = 1'b0;
        en_cd = $urandom_range(0, 6);
      end else begin
        enable = 1'b1;
      end
      lock_cd--;
      if (lock_cd <= 0) begin
        pll_locked = ($urandom_range(0, 3) != 0);
        lock_cd = pll_locked ? $urandom_range(1, 120) : $urandom_range(1, 30);
      end
      if ($urandom_range(0, 149) == 0)
        tick_per = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 12);
      step();
    end

    rst = 1'b0;
    enable = 1'b0;
    repeat (3) step();
    @(negedge clk);
    @(negedge clk);
    chk(cyc, "scoreboard_drain", n_pop, n_push);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
